// File: rtl/uart_ctrl_tx_engine_pkg.sv
// Shared types and helpers for the uart_ctrl transmit engine.
package uart_ctrl_tx_pkg;

  localparam int TX_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Maps the LCR word-length select onto the number of data bits (5..8).
  function automatic logic [3:0] wlsToBits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_ctrl_tx_engine_if.sv
// THR write handshake between the APB register file and the TX engine.
interface uart_ctrl_tx_engine_if;
  import uart_ctrl_tx_pkg::*;

  logic                 wr_valid;
  logic [TX_DATA_W-1:0] wr_data;
  logic                 wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_ctrl_tx_engine_fifo.sv
// Byte-wide TX FIFO with a separate fill-count register and synchronous flush.
// Pointers wrap modulo DEPTH; writes while full and reads while empty are ignored.
module uart_ctrl_tx_fifo
  import uart_ctrl_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [TX_DATA_W-1:0]   i_data,
  output logic [TX_DATA_W-1:0]   o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [TX_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [AW:0]          r_count;
  logic                 w_push;
  logic                 w_pop;

  assign w_push = i_push && (r_count != FULL);
  assign w_pop  = i_pop && (r_count != '0);

  // Pointer and count bookkeeping; a flush wins over any same-cycle push or pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; left unreset because the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_push && !i_clear) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/uart_ctrl_tx_engine.sv
// UART transmit engine: TX FIFO feeding a start/data/stop serializer that
// advances one bit every OVERSAMPLE pulses of the 16x baud enable.
// Optional parity support is built when UART_TX_PARITY_EN is defined.
module uart_ctrl_tx_engine
  import uart_ctrl_tx_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_ctrl_tx_engine_if.slave   wrIf,
  input  logic                   i_baud_en,
  input  logic                   i_fifo_clear,
  input  logic [1:0]             i_lcr_wls,
  input  logic                   i_lcr_stb,
`ifdef UART_TX_PARITY_EN
  input  logic                   i_lcr_pen,
  input  logic                   i_lcr_eps,
  input  logic                   i_lcr_sp,
`endif
  output logic                   o_txd,
  output logic                   o_tx_busy,
  output logic                   o_thre,
  output logic                   o_temt,
  output logic [$clog2(DEPTH):0] o_tx_fifo_ptr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  tx_state_e            r_state, w_stateNext;
  logic [3:0]           r_baudCnt, w_baudCntNext;
  logic [2:0]           r_bitIdx, w_bitIdxNext;
  logic [2:0]           r_lastIdx, w_lastIdxNext;
  logic [TX_DATA_W-1:0] r_shift, w_shiftNext;
  logic                 r_stb, w_stbNext;
  logic                 r_txd, w_txdNext;
  logic                 w_pop;
  logic                 w_bitEnd;
  logic [TX_DATA_W-1:0] w_fifoData;
  logic [CW-1:0]        w_count;

`ifdef UART_TX_PARITY_EN
  logic                 r_pen, w_penNext;
  logic                 r_parBit, w_parBitNext;
  logic [TX_DATA_W-1:0] w_loadMask;
  logic                 w_loadParity;

  assign w_loadMask   = 8'hFF >> (4'd8 - wlsToBits(i_lcr_wls));
  assign w_loadParity = i_lcr_sp  ? ~i_lcr_eps :
                        i_lcr_eps ? ^(w_fifoData & w_loadMask) :
                                    ~^(w_fifoData & w_loadMask);
`endif

  uart_ctrl_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (wrIf.wr_valid),
    .i_pop   (w_pop),
    .i_clear (i_fifo_clear),
    .i_data  (wrIf.wr_data),
    .o_data  (w_fifoData),
    .o_count (w_count)
  );

  assign w_bitEnd = i_baud_en && (r_baudCnt == LAST_TICK);

  // Serializer register bank; reset forces the line back to idle-high at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_lastIdx <= '0;
      r_shift   <= '0;
      r_stb     <= 1'b0;
      r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_pen     <= 1'b0;
      r_parBit  <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_baudCnt <= w_baudCntNext;
      r_bitIdx  <= w_bitIdxNext;
      r_lastIdx <= w_lastIdxNext;
      r_shift   <= w_shiftNext;
      r_stb     <= w_stbNext;
      r_txd     <= w_txdNext;
`ifdef UART_TX_PARITY_EN
      r_pen     <= w_penNext;
      r_parBit  <= w_parBitNext;
`endif
    end
  end

  // Next-state, next line level and FIFO pop; LCR is sampled only when a character loads.
  always_comb begin
    w_stateNext   = r_state;
    w_baudCntNext = r_baudCnt;
    w_bitIdxNext  = r_bitIdx;
    w_lastIdxNext = r_lastIdx;
    w_shiftNext   = r_shift;
    w_stbNext     = r_stb;
    w_txdNext     = r_txd;
    w_pop         = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_penNext     = r_pen;
    w_parBitNext  = r_parBit;
`endif

    if (r_state != IDLE && i_baud_en) begin
      w_baudCntNext = w_bitEnd ? 4'd0 : r_baudCnt + 4'd1;
    end

    case (r_state)
      IDLE: begin
        w_baudCntNext = '0;
        w_bitIdxNext  = '0;
        w_txdNext     = 1'b1;
        if (w_count != '0 && !i_fifo_clear) begin
          w_pop         = 1'b1;
          w_stateNext   = START;
          w_shiftNext   = w_fifoData;
          w_lastIdxNext = 3'(wlsToBits(i_lcr_wls) - 4'd1);
          w_stbNext     = i_lcr_stb;
          w_txdNext     = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_penNext     = i_lcr_pen;
          w_parBitNext  = w_loadParity;
`endif
        end
      end
      START: begin
        if (w_bitEnd) begin
          w_stateNext = DATA;
          w_txdNext   = r_shift[0];
        end
      end
      DATA: begin
        if (w_bitEnd) begin
          if (r_bitIdx == r_lastIdx) begin
            w_bitIdxNext = '0;
`ifdef UART_TX_PARITY_EN
            if (r_pen) begin
              w_stateNext = PARITY;
              w_txdNext   = r_parBit;
            end else
`endif
            begin
              w_stateNext = STOP;
              w_txdNext   = 1'b1;
            end
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
            w_shiftNext  = r_shift >> 1;
            w_txdNext    = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = STOP;
          w_txdNext   = 1'b1;
        end
      end
`endif
      STOP: begin
        w_txdNext = 1'b1;
        if (w_bitEnd) begin
          if (r_bitIdx == {2'b00, r_stb}) begin
            w_stateNext  = IDLE;
            w_bitIdxNext = '0;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_txdNext   = 1'b1;
      end
    endcase
  end

  assign wrIf.wr_ready = (w_count != FULL);
  assign o_txd         = r_txd;
  assign o_tx_busy     = (r_state != IDLE);
  assign o_thre        = (w_count == '0);
  assign o_temt        = o_thre && !o_tx_busy;
  assign o_tx_fifo_ptr = w_count;

endmodule

// File: tb/tb_uart_ctrl_tx_engine.sv
// Scoreboard bench for uart_ctrl_tx_engine: stimulus queues expected frames,
// a line monitor decodes txd per baud pulse and compares against the queue.
module tb_uart_ctrl_tx_engine;

  logic       clock;
  logic       reset;
  logic       baud_en;
  logic       fifo_clear;
  logic [1:0] lcr_wls;
  logic       lcr_stb;
`ifdef UART_TX_PARITY_EN
  logic       lcr_pen;
  logic       lcr_eps;
  logic       lcr_sp;
`endif
  logic       txd;
  logic       tx_busy;
  logic       thre;
  logic       temt;
  logic [4:0] tx_fifo_ptr;

  uart_ctrl_tx_engine_if wrIf();

  uart_ctrl_tx_engine #(.DEPTH(16), .OVERSAMPLE(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .wrIf          (wrIf),
    .i_baud_en     (baud_en),
    .i_fifo_clear  (fifo_clear),
    .i_lcr_wls     (lcr_wls),
    .i_lcr_stb     (lcr_stb),
`ifdef UART_TX_PARITY_EN
    .i_lcr_pen     (lcr_pen),
    .i_lcr_eps     (lcr_eps),
    .i_lcr_sp      (lcr_sp),
`endif
    .o_txd         (txd),
    .o_tx_busy     (tx_busy),
    .o_thre        (thre),
    .o_temt        (temt),
    .o_tx_fifo_ptr (tx_fifo_ptr)
  );

  typedef struct {
    logic [7:0] data;
    int         nBits;
    int         nStop;
    bit         hasPar;
    bit         parBit;
  } frame_t;

  frame_t expQ[$];
  int     passCount  = 0;
  int     checkCount = 0;
  int     frameNo    = 0;
  bit     baudRun    = 1'b1;
  bit     baudPhase  = 1'b0;

  // 100 MHz-style clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Baud enable: one pulse every second clock while baudRun is set
  initial begin
    baud_en = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      baudPhase = ~baudPhase;
      baud_en   = baudRun && baudPhase;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic expectFrame(input logic [7:0] data, input int nBits, input int nStop,
                             input bit hasPar, input bit parBit);
    frame_t f;
    f.data = data; f.nBits = nBits; f.nStop = nStop; f.hasPar = hasPar; f.parBit = parBit;
    expQ.push_back(f);
  endtask

  function automatic logic expBit(input frame_t f, input int b);
    if (b == 0) return 1'b0;
    if (b <= f.nBits) return f.data[b-1];
    if (f.hasPar && b == f.nBits + 1) return f.parBit;
    return 1'b1;
  endfunction

  // Single THR write, waiting (bounded) for space in the FIFO
  task automatic applyStimulus(input logic [7:0] data);
    int n = 0;
    @(negedge clock);
    while (!wrIf.wr_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!wrIf.wr_ready) checkOutput("wr_ready_timeout", {31'b0, wrIf.wr_ready}, 1);
    wrIf.wr_valid = 1'b1;
    wrIf.wr_data  = data;
    @(posedge clock);
    #1;
    wrIf.wr_valid = 1'b0;
  endtask

  // Back-to-back 8N1 writes, one per clock, expected frames queued in order
  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      expectFrame(8'(first + 8'(i)), 8, 1, 1'b0, 1'b0);
      @(negedge clock);
      wrIf.wr_valid = 1'b1;
      wrIf.wr_data  = 8'(first + 8'(i));
    end
    @(negedge clock);
    wrIf.wr_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    @(negedge clock);
    while (!temt && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, {31'b0, temt}, 1);
  endtask

  // Line monitor: each bit must hold its expected level for all 16 baud pulses
  initial begin : monitor
    frame_t     cur;
    logic [15:0] got;
    int          nTot;
    int          bitNo;
    int          sIdx;
    bit          aborted;
    forever begin
      @(negedge clock);
      if (!reset && txd === 1'b0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
          while (txd === 1'b0 && !reset) @(negedge clock);
        end else begin
          cur     = expQ.pop_front();
          nTot    = 1 + cur.nBits + (cur.hasPar ? 1 : 0) + cur.nStop;
          bitNo   = 0;
          sIdx    = 0;
          aborted = 1'b0;
          got     = '0;
          while (bitNo < nTot && !aborted) begin
            if (reset) begin
              aborted = 1'b1;
            end else if (baud_en) begin
              got[sIdx] = txd;
              sIdx++;
              if (sIdx == 16) begin
                checkOutput($sformatf("frame%0d_bit%0d", frameNo, bitNo), {16'b0, got},
                            expBit(cur, bitNo) ? 32'h0000_FFFF : 32'h0);
                bitNo++;
                sIdx = 0;
              end
            end
            if (bitNo < nTot && !aborted) @(negedge clock);
          end
          frameNo++;
        end
      end
    end
  end

  initial begin : stimulus
    reset         = 1'b1;
    fifo_clear    = 1'b0;
    lcr_wls       = 2'd3;
    lcr_stb       = 1'b0;
`ifdef UART_TX_PARITY_EN
    lcr_pen       = 1'b0;
    lcr_eps       = 1'b0;
    lcr_sp        = 1'b0;
`endif
    wrIf.wr_valid = 1'b0;
    wrIf.wr_data  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] reset values");
    checkOutput("rst_txd", {31'b0, txd}, 1);
    checkOutput("rst_busy", {31'b0, tx_busy}, 0);
    checkOutput("rst_thre", {31'b0, thre}, 1);
    checkOutput("rst_temt", {31'b0, temt}, 1);
    checkOutput("rst_wr_ready", {31'b0, wrIf.wr_ready}, 1);
    checkOutput("rst_ptr", {27'b0, tx_fifo_ptr}, 0);

    $display("[TB] single 8N1 byte 0xA5");
    expectFrame(8'hA5, 8, 1, 1'b0, 1'b0);
    applyStimulus(8'hA5);
    @(negedge clock);
    checkOutput("t1_ptr_push", {27'b0, tx_fifo_ptr}, 1);
    @(negedge clock);
    checkOutput("t1_ptr_pop", {27'b0, tx_fifo_ptr}, 0);
    checkOutput("t1_txd_start", {31'b0, txd}, 0);
    checkOutput("t1_busy", {31'b0, tx_busy}, 1);
    waitIdle("t1_idle", 1000);
    checkOutput("t1_txd_idle", {31'b0, txd}, 1);

    $display("[TB] fill with serializer stalled");
    baudRun = 1'b0;
    burst(8'h10, 17);
    checkOutput("t2_ptr_full", {27'b0, tx_fifo_ptr}, 16);
    checkOutput("t2_wr_ready_full", {31'b0, wrIf.wr_ready}, 0);
    checkOutput("t2_thre", {31'b0, thre}, 0);
    wrIf.wr_valid = 1'b1;
    wrIf.wr_data  = 8'hEE;
    @(negedge clock);
    wrIf.wr_valid = 1'b0;
    @(negedge clock);
    checkOutput("t2_ptr_drop", {27'b0, tx_fifo_ptr}, 16);
    baudRun = 1'b1;
    waitIdle("t2_drain", 8000);

    $display("[TB] push+pop at count 5, 40-byte wrap");
    baudRun = 1'b0;
    expectFrame(8'h40, 8, 1, 1'b0, 1'b0);
    applyStimulus(8'h40);
    burst(8'h41, 5);
    checkOutput("t3_ptr5", {27'b0, tx_fifo_ptr}, 5);
    baudRun = 1'b1;
    begin
      int n = 0;
      while (tx_busy && n < 1000) begin
        @(negedge clock);
        n++;
      end
    end
    checkOutput("t3_frame_end", {31'b0, tx_busy}, 0);
    expectFrame(8'h46, 8, 1, 1'b0, 1'b0);
    wrIf.wr_valid = 1'b1;
    wrIf.wr_data  = 8'h46;
    @(posedge clock);
    #1;
    wrIf.wr_valid = 1'b0;
    @(negedge clock);
    checkOutput("t3_push_pop_hold", {27'b0, tx_fifo_ptr}, 5);
    for (int i = 7; i < 40; i++) begin
      expectFrame(8'(8'h40 + 8'(i)), 8, 1, 1'b0, 1'b0);
      applyStimulus(8'(8'h40 + 8'(i)));
    end
    waitIdle("t3_drain", 16000);

    $display("[TB] word lengths and stop bits");
    lcr_wls = 2'd0; lcr_stb = 1'b1;
    expectFrame(8'h1F, 5, 2, 1'b0, 1'b0);
    applyStimulus(8'h1F);
    waitIdle("t4_wls5", 1000);
    lcr_wls = 2'd1; lcr_stb = 1'b0;
    expectFrame(8'h2C, 6, 1, 1'b0, 1'b0);
    applyStimulus(8'h2C);
    waitIdle("t4_wls6", 1000);
    lcr_wls = 2'd2; lcr_stb = 1'b1;
    expectFrame(8'h55, 7, 2, 1'b0, 1'b0);
    applyStimulus(8'h55);
    waitIdle("t4_wls7", 1000);

    $display("[TB] LCR change mid-character");
    lcr_wls = 2'd3; lcr_stb = 1'b0;
    expectFrame(8'hC3, 8, 1, 1'b0, 1'b0);
    expectFrame(8'h0A, 5, 2, 1'b0, 1'b0);
    applyStimulus(8'hC3);
    applyStimulus(8'h0A);
    repeat (20) @(negedge clock);
    lcr_wls = 2'd0; lcr_stb = 1'b1;
    waitIdle("t4_lcr_next", 2000);
    lcr_wls = 2'd3; lcr_stb = 1'b0;

    $display("[TB] fifo_clear mid-character");
    burst(8'h80, 9);
    checkOutput("t5_ptr8", {27'b0, tx_fifo_ptr}, 8);
    repeat (40) @(negedge clock);
    fifo_clear = 1'b1;
    @(negedge clock);
    fifo_clear = 1'b0;
    expQ.delete();
    checkOutput("t5_ptr_cleared", {27'b0, tx_fifo_ptr}, 0);
    checkOutput("t5_thre", {31'b0, thre}, 1);
    checkOutput("t5_busy", {31'b0, tx_busy}, 1);
    waitIdle("t5_idle", 1000);

    $display("[TB] reset during data bit 3");
    expectFrame(8'hA5, 8, 1, 1'b0, 1'b0);
    applyStimulus(8'hA5);
    applyStimulus(8'h33);
    repeat (140) @(negedge clock);
    checkOutput("t6_txd_bit3", {31'b0, txd}, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_txd", {31'b0, txd}, 1);
    checkOutput("t6_async_ptr", {27'b0, tx_fifo_ptr}, 0);
    checkOutput("t6_async_busy", {31'b0, tx_busy}, 0);
    repeat (3) @(negedge clock);
    expQ.delete();
    reset = 1'b0;
    repeat (400) @(negedge clock);
    checkOutput("t6_temt_after", {31'b0, temt}, 1);
    checkOutput("t6_txd_after", {31'b0, txd}, 1);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity");
    lcr_pen = 1'b1; lcr_eps = 1'b1; lcr_sp = 1'b0;
    expectFrame(8'h07, 8, 1, 1'b1, 1'b1);
    applyStimulus(8'h07);
    waitIdle("t7_even", 1000);
    lcr_eps = 1'b0;
    expectFrame(8'h07, 8, 1, 1'b1, 1'b0);
    applyStimulus(8'h07);
    waitIdle("t7_odd", 1000);
    lcr_wls = 2'd0; lcr_sp = 1'b1;
    expectFrame(8'h03, 5, 1, 1'b1, 1'b1);
    applyStimulus(8'h03);
    waitIdle("t7_stick", 1000);
    lcr_pen = 1'b0; lcr_sp = 1'b0; lcr_wls = 2'd3;
`endif

    repeat (4) @(negedge clock);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
